// File: rtl/anscode_uart_reporter_pkg.sv
// Shared types, constants and ASCII helpers for the answer-code UART reporter.
package anscode_uart_reporter_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int unsigned FRAME_BYTES = 10;

  // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Byte idx of the frame for a given word: 8 hex digits MSB nibble first, then CR, LF.
  function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [3:0] idx);
    logic [31:0] sh;
    sh = word >> (5'd28 - {idx[2:0], 2'b00});
    if (idx < 4'd8) begin
      return nibble_to_ascii(sh[3:0]);
    end else if (idx == 4'd8) begin
      return ASCII_CR;
    end
    return ASCII_LF;
  endfunction

endpackage

// File: rtl/anscode_uart_reporter_uart_tx_byte.sv
// 8N1 byte serialiser; accepts a new byte in the last stop-bit cycle so bytes chain gap-free.
module uart_tx_byte
  import anscode_uart_reporter_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_o   = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStart;
          sh_d    = byte_i;
          cnt_d   = '0;
        end
      end
      StStart: begin
        txd_o = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        txd_o = sh_q[0];
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          done_o = 1'b1;
          cnt_d  = '0;
          if (start_i) begin
            state_d = StStart;
            sh_d    = byte_i;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: rtl/anscode_uart_reporter.sv
// Sends the answer-code word as "XXXXXXXX\r\n" over UART whenever it changes and i_en is high.
module anscode_uart_reporter
  import anscode_uart_reporter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic        o_txd,
  output logic        o_busy
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam logic [3:0] LastIdx = 4'(FRAME_BYTES - 1);

  logic        busy_q, busy_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] last_q, last_d;
  logic        trigger;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        tx_txd;

  // Only compared while idle, so mid-frame changes coalesce into the value seen on return.
  assign trigger = !busy_q && i_en && (i_data != last_q);

  always_comb begin
    busy_d   = busy_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    last_d   = last_q;
    tx_start = 1'b0;
    tx_byte  = '0;
    if (trigger) begin
      busy_d   = 1'b1;
      idx_d    = '0;
      frame_d  = i_data;
      last_d   = i_data;
      tx_start = 1'b1;
      tx_byte  = frame_byte(i_data, 4'd0);
    end else if (busy_q && tx_done) begin
      if (idx_q == LastIdx) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d    = idx_q + 1'b1;
        tx_start = 1'b1;
        tx_byte  = frame_byte(frame_q, idx_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      idx_q   <= '0;
      frame_q <= '0;
      last_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk_i  (clk),
    .rst_i  (reset),
    .start_i(tx_start),
    .byte_i (tx_byte),
    .txd_o  (tx_txd),
    .done_o (tx_done)
  );

  assign o_txd  = tx_txd;
  assign o_busy = busy_q;

endmodule
